// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop input synchronizer, mid-bit sampling FSM,
// registered data/valid/frame_err/busy outputs.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       idx, idx_n;
    logic [7:0]       shift, shift_n;
    logic [7:0]       data_n;
    logic             valid_n, frame_err_n;
    logic             rx_meta, rx_s;

    // Synchronizer resets to the idle-high level so reset release never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shift     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            shift     <= shift_n;
            data      <= data_n;
            valid     <= valid_n;
            frame_err <= frame_err_n;
            busy      <= (state_n != IDLE);
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_n     = state;
        cnt_n       = cnt + CNT_W'(1);
        idx_n       = idx;
        shift_n     = shift;
        data_n      = data;
        valid_n     = 1'b0;
        frame_err_n = 1'b0;

        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rx_s) state_n = START;
            end
            START: begin
                if (cnt == HALF_CNT) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    // A line back high at mid start bit was only a glitch.
                    state_n = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == LAST_CNT) begin
                    cnt_n        = '0;
                    shift_n[idx] = rx_s;
                    idx_n        = idx + 3'd1;
                    if (idx == 3'd7) state_n = STOP;
                end
            end
            STOP: begin
                if (cnt == LAST_CNT) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                    if (rx_s) begin
                        data_n  = shift;
                        valid_n = 1'b1;
                    end else begin
                        frame_err_n = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: one instance at 16 clks/bit, one at 4 clks/bit.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx16 = 1'b1;
    logic       rx4 = 1'b1;
    logic [7:0] data16, data4;
    logic       valid16, valid4, ferr16, ferr4, busy16, busy4;

    int checks = 0;
    int failures = 0;

    int v16_cnt = 0, f16_cnt = 0, v4_cnt = 0, f4_cnt = 0, both_cnt = 0;
    bit busy_seen = 1'b0;
    logic [7:0] log16[$];

    always #5 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT(16)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx16), .data(data16),
        .valid(valid16), .frame_err(ferr16), .busy(busy16)
    );

    uart_rx #(.CLKS_PER_BIT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .rx(rx4), .data(data4),
        .valid(valid4), .frame_err(ferr4), .busy(busy4)
    );

    // Outputs are observed on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (valid16 === 1'b1) begin
            v16_cnt++;
            log16.push_back(data16);
        end
        if (ferr16 === 1'b1) f16_cnt++;
        if (valid4 === 1'b1) v4_cnt++;
        if (ferr4 === 1'b1) f4_cnt++;
        if ((valid16 & ferr16) === 1'b1 || (valid4 & ferr4) === 1'b1) both_cnt++;
        if (busy16 === 1'b1) busy_seen = 1'b1;
    end

    // Entered and left on a falling edge.
    task automatic hold(input bit which, input logic val, input int n);
        if (which) rx4 = val; else rx16 = val;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input bit which, input logic [7:0] b, input logic stop_bit, input int cpb);
        hold(which, 1'b0, cpb);
        for (int i = 0; i < 8; i++) hold(which, b[i], cpb);
        hold(which, stop_bit, cpb);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++; if (data16 !== 8'h00) begin failures++; $display("FAIL reset_data16: got %h expected 00", data16); end
        checks++; if (valid16 !== 1'b0) begin failures++; $display("FAIL reset_valid16: got %b expected 0", valid16); end
        checks++; if (ferr16 !== 1'b0) begin failures++; $display("FAIL reset_ferr16: got %b expected 0", ferr16); end
        checks++; if (busy16 !== 1'b0) begin failures++; $display("FAIL reset_busy16: got %b expected 0", busy16); end
        checks++; if ({data4, valid4, ferr4, busy4} !== 11'h000) begin
            failures++; $display("FAIL reset_dut4: got %h expected 000", {data4, valid4, ferr4, busy4});
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_frame_a5;
        int v0, f0;
        v0 = v16_cnt; f0 = f16_cnt;
        send(1'b0, 8'hA5, 1'b1, 16);
        hold(1'b0, 1'b1, 4);
        checks++; if (v16_cnt - v0 !== 1) begin failures++; $display("FAIL a5_valid_cycles: got %0d expected 1", v16_cnt - v0); end
        checks++; if (f16_cnt - f0 !== 0) begin failures++; $display("FAIL a5_ferr_cycles: got %0d expected 0", f16_cnt - f0); end
        checks++; if (data16 !== 8'hA5) begin failures++; $display("FAIL a5_data: got %h expected a5", data16); end
        checks++; if (busy16 !== 1'b0) begin failures++; $display("FAIL a5_busy_after: got %b expected 0", busy16); end
    endtask

    task automatic test_glitch;
        int v0, f0;
        v0 = v16_cnt; f0 = f16_cnt;
        busy_seen = 1'b0;
        hold(1'b0, 1'b0, 4);
        hold(1'b0, 1'b1, 20);
        checks++; if (busy_seen !== 1'b1) begin failures++; $display("FAIL glitch_busy_seen: got %b expected 1", busy_seen); end
        checks++; if (busy16 !== 1'b0) begin failures++; $display("FAIL glitch_busy_after: got %b expected 0", busy16); end
        checks++; if ((v16_cnt - v0) + (f16_cnt - f0) !== 0) begin
            failures++; $display("FAIL glitch_pulses: got %0d expected 0", (v16_cnt - v0) + (f16_cnt - f0));
        end
        checks++; if (data16 !== 8'hA5) begin failures++; $display("FAIL glitch_data: got %h expected a5", data16); end
    endtask

    task automatic test_frame_err;
        int v0, f0;
        v0 = v16_cnt; f0 = f16_cnt;
        send(1'b0, 8'h3C, 1'b0, 16);
        hold(1'b0, 1'b1, 24);
        checks++; if (f16_cnt - f0 !== 1) begin failures++; $display("FAIL ferr_cycles: got %0d expected 1", f16_cnt - f0); end
        checks++; if (v16_cnt - v0 !== 0) begin failures++; $display("FAIL ferr_valid_cycles: got %0d expected 0", v16_cnt - v0); end
        checks++; if (data16 !== 8'hA5) begin failures++; $display("FAIL ferr_data: got %h expected a5", data16); end
    endtask

    task automatic test_back_to_back;
        int v0;
        v0 = v16_cnt;
        send(1'b0, 8'h00, 1'b1, 16);
        send(1'b0, 8'hFF, 1'b1, 16);
        hold(1'b0, 1'b1, 4);
        checks++; if (v16_cnt - v0 !== 2) begin failures++; $display("FAIL b2b_valid_cycles: got %0d expected 2", v16_cnt - v0); end
        checks++; if (log16.size() < v0 + 2 || log16[v0] !== 8'h00) begin
            failures++; $display("FAIL b2b_first_data: got %0d entries, expected 00 at index %0d", log16.size(), v0);
        end
        checks++; if (log16.size() < v0 + 2 || log16[v0 + 1] !== 8'hFF) begin
            failures++; $display("FAIL b2b_second_data: got %0d entries, expected ff at index %0d", log16.size(), v0 + 1);
        end
    endtask

    task automatic test_reset_mid;
        int v0;
        logic [7:0] b;
        v0 = v16_cnt;
        b = 8'h77;
        hold(1'b0, 1'b0, 16);
        for (int i = 0; i < 3; i++) hold(1'b0, b[i], 16);
        hold(1'b0, b[3], 8);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if ({data16, valid16, ferr16, busy16} !== 11'h000) begin
            failures++; $display("FAIL midreset_outputs: got %h expected 000", {data16, valid16, ferr16, busy16});
        end
        rst_n = 1'b1;
        hold(1'b0, 1'b1, 40);
        checks++; if (busy16 !== 1'b0) begin failures++; $display("FAIL midreset_busy_idle: got %b expected 0", busy16); end
        send(1'b0, 8'h5A, 1'b1, 16);
        hold(1'b0, 1'b1, 4);
        checks++; if (v16_cnt - v0 !== 1) begin failures++; $display("FAIL midreset_valid_cycles: got %0d expected 1", v16_cnt - v0); end
        checks++; if (data16 !== 8'h5A) begin failures++; $display("FAIL midreset_data: got %h expected 5a", data16); end
    endtask

    task automatic test_cpb4;
        int v0, f0;
        v0 = v4_cnt; f0 = f4_cnt;
        send(1'b1, 8'h81, 1'b1, 4);
        hold(1'b1, 1'b1, 4);
        checks++; if (v4_cnt - v0 !== 1) begin failures++; $display("FAIL cpb4_valid_cycles: got %0d expected 1", v4_cnt - v0); end
        checks++; if (f4_cnt - f0 !== 0) begin failures++; $display("FAIL cpb4_ferr_cycles: got %0d expected 0", f4_cnt - f0); end
        checks++; if (data4 !== 8'h81) begin failures++; $display("FAIL cpb4_data: got %h expected 81", data4); end
        checks++; if (busy4 !== 1'b0) begin failures++; $display("FAIL cpb4_busy_after: got %b expected 0", busy4); end
    endtask

    task automatic test_exclusive;
        checks++; if (both_cnt !== 0) begin failures++; $display("FAIL valid_ferr_overlap: got %0d cycles expected 0", both_cnt); end
    endtask

    initial begin
        test_reset();
        test_frame_a5();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_reset_mid();
        test_cpb4();
        test_exclusive();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
